vector_ex_sequencer: RTL and testbench

VECTOR_EX_SEQUENCER -- requirements
Module: vector_ex_sequencer

---
 rtl/vec_pkg.sv | 29 ++
 rtl/vec_lane_alu.sv | 62 ++++++
 rtl/vector_ex_sequencer.sv | 138 +++++++++++++
 tb/tb_vector_ex_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector execute stage.
// Holds the ALU operation codes, the operand-B source encodings and the
// sequencer state type; the ID/EX and decode logic import the same package
// so every stage agrees on the encodings.
package vec_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_MUL   = 3'b101,
    OP_SHL   = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_t;

  // Operand-B source. Only the immediate encoding is special; every other
  // value selects the vector register lane.
  localparam logic [1:0] VSI_VEC = 2'b00;
  localparam logic [1:0] VSI_IMM = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane N-bit ALU.
// Ports:
//   op  - operation code
//   a   - lane operand A
//   b   - lane operand B (already muxed between immediate and vector lane)
//   y   - lane result
// Build option: VEC_SAT_EN makes ADD/SUB saturate as signed two's complement;
// without it they wrap modulo 2^N.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int N = 8
) (
  input  alu_op_t        op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   y
);

  logic [N-1:0] add_r;
  logic [N-1:0] sub_r;

`ifdef VEC_SAT_EN
  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  // One guard bit: the result overflowed when the two top bits disagree,
  // and the guard bit then tells the direction of the overflow.
  logic [N:0] sum_x;
  logic [N:0] dif_x;

  always_comb begin
    sum_x = {a[N-1], a} + {b[N-1], b};
    dif_x = {a[N-1], a} - {b[N-1], b};
    add_r = sum_x[N-1:0];
    sub_r = dif_x[N-1:0];
    if (sum_x[N] != sum_x[N-1]) add_r = sum_x[N] ? SAT_MIN : SAT_MAX;
    if (dif_x[N] != dif_x[N-1]) sub_r = dif_x[N] ? SAT_MIN : SAT_MAX;
  end
`else
  always_comb begin
    add_r = a + b;
    sub_r = a - b;
  end
`endif

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:   y = add_r;
      OP_SUB:   y = sub_r;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_MUL:   y = a * b;
      OP_SHL:   y = a << b[2:0];
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/vector_ex_sequencer.sv
// Multi-cycle vector execute stage: captures one vector ALU operation from
// ID/EX and computes LPC lanes per clock until all R lanes are done.
// Ports:
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   issue_valid  - ID/EX presents an operation (alu_op, vsi_flag, wa3_in,
//                  imm_in, src_a, src_b)
//   stall        - holds ID/EX and fetch/decode while lanes are computed
//   res_valid    - result strobe, high for the single DONE cycle
//   res_wa3      - destination register of the result
//   result       - packed result lanes, lane i at [i*N +: N]
//   zero_flag    - all result lanes zero, valid with res_valid
//   dbg_state    - current sequencer state for observation
// Handshake: an operation is accepted on any rising edge where issue_valid
// is high and the sequencer is not in RUN (stall low); issue_valid is not
// sampled while stall is high. res_valid has no backpressure.
// Build option: VEC_SAT_EN selects saturating ADD/SUB in the lane ALUs.
module vector_ex_sequencer
  import vec_pkg::*;
#(
  parameter int N   = 8,
  parameter int R   = 6,
  parameter int LPC = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           issue_valid,
  input  logic [2:0]     alu_op,
  input  logic [1:0]     vsi_flag,
  input  logic [3:0]     wa3_in,
  input  logic [N-1:0]   imm_in,
  input  logic [R*N-1:0] src_a,
  input  logic [R*N-1:0] src_b,
  output logic           stall,
  output logic           res_valid,
  output logic [3:0]     res_wa3,
  output logic [R*N-1:0] result,
  output logic           zero_flag,
  output state_t         dbg_state
);

  localparam int IW = $clog2(R + 1);

  state_t           state, state_n;
  logic [IW-1:0]    idx;
  alu_op_t          op_q;
  logic [1:0]       vsi_q;
  logic [3:0]       wa3_q;
  logic [N-1:0]     imm_q;
  logic [R*N-1:0]   a_q, b_q;
  logic [R*N-1:0]   result_n;
  logic             capture;
  logic             last;

  logic [N-1:0]     lane_a [LPC];
  logic [N-1:0]     lane_b [LPC];
  logic [N-1:0]     lane_y [LPC];

  assign capture   = issue_valid && (state != ST_RUN);
  // idx is only advanced on non-final edges, so idx+LPC-1 never leaves
  // the lane range and the selects below stay in bounds.
  assign last      = (int'(idx) + LPC) >= R;
  assign stall     = (state == ST_RUN);
  assign res_valid = (state == ST_DONE);
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (issue_valid) state_n = ST_RUN;
      ST_RUN:  if (last)        state_n = ST_DONE;
      ST_DONE: state_n = issue_valid ? ST_RUN : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Select the LPC lanes starting at idx for the shared lane ALUs.
  always_comb begin
    for (int j = 0; j < LPC; j++) begin
      lane_a[j] = a_q[(int'(idx) + j) * N +: N];
      lane_b[j] = (vsi_q == VSI_IMM) ? imm_q : b_q[(int'(idx) + j) * N +: N];
    end
  end

  for (genvar g = 0; g < LPC; g++) begin : g_lane
    vec_lane_alu #(.N(N)) u_alu (
      .op (op_q),
      .a  (lane_a[g]),
      .b  (lane_b[g]),
      .y  (lane_y[g])
    );
  end

  always_comb begin
    result_n = result;
    for (int j = 0; j < LPC; j++) begin
      result_n[(int'(idx) + j) * N +: N] = lane_y[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      op_q      <= OP_ADD;
      vsi_q     <= '0;
      wa3_q     <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result    <= '0;
      res_wa3   <= '0;
      zero_flag <= 1'b0;
    end else begin
      state <= state_n;
      if (capture) begin
        op_q   <= alu_op_t'(alu_op);
        vsi_q  <= vsi_flag;
        wa3_q  <= wa3_in;
        imm_q  <= imm_in;
        a_q    <= src_a;
        b_q    <= src_b;
        idx    <= '0;
        result <= '0;
      end else if (state == ST_RUN) begin
        result <= result_n;
        if (last) begin
          // Status is published together with the final lanes so that
          // res_wa3 and zero_flag hold alongside result until next op.
          zero_flag <= ~|result_n;
          res_wa3   <= wa3_q;
        end else begin
          idx <= idx + IW'(LPC);
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_ex_sequencer.sv
// Self-checking bench for vector_ex_sequencer: a lane-wise reference model,
// an expected-result queue, a per-cycle compare process, directed scenarios
// with literal expectations and a randomized issue phase.
module tb_vector_ex_sequencer;
  import vec_pkg::*;

  localparam int N   = 8;
  localparam int R   = 6;
  localparam int LPC = 2;
  localparam int W   = R * N;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           issue_valid = 1'b0;
  logic [2:0]     alu_op = '0;
  logic [1:0]     vsi_flag = '0;
  logic [3:0]     wa3_in = '0;
  logic [N-1:0]   imm_in = '0;
  logic [W-1:0]   src_a = '0;
  logic [W-1:0]   src_b = '0;
  logic           stall;
  logic           res_valid;
  logic [3:0]     res_wa3;
  logic [W-1:0]   result;
  logic           zero_flag;
  state_t         dbg_state;

  int errors = 0;
  int checks = 0;

  vector_ex_sequencer #(.N(N), .R(R), .LPC(LPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .alu_op      (alu_op),
    .vsi_flag    (vsi_flag),
    .wa3_in      (wa3_in),
    .imm_in      (imm_in),
    .src_a       (src_a),
    .src_b       (src_b),
    .stall       (stall),
    .res_valid   (res_valid),
    .res_wa3     (res_wa3),
    .result      (result),
    .zero_flag   (zero_flag),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_result(input logic [2:0] op, input logic [1:0] vsi,
                                                input logic [N-1:0] imm,
                                                input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [N-1:0] x, y, z;
    int s;
    r = '0;
    for (int i = 0; i < R; i++) begin
      x = a[i*N +: N];
      y = (vsi == 2'b01) ? imm : b[i*N +: N];
      z = '0;
      case (op)
        3'd0, 3'd1: begin
          if (op == 3'd0) s = int'($signed(x)) + int'($signed(y));
          else            s = int'($signed(x)) - int'($signed(y));
`ifdef VEC_SAT_EN
          if (s >  (1 << (N-1)) - 1) s =  (1 << (N-1)) - 1;
          if (s < -(1 << (N-1)))     s = -(1 << (N-1));
`endif
          z = N'(s);
        end
        3'd2: z = x & y;
        3'd3: z = x | y;
        3'd4: z = x ^ y;
        3'd5: z = N'(int'(x) * int'(y));
        3'd6: z = N'(int'(x) << int'(y[2:0]));
        default: z = y;
      endcase
      r[i*N +: N] = z;
    end
    return r;
  endfunction

  // Timeline model: an accepted operation keeps the block busy for R/LPC
  // cycles, then shows its result for one strobe cycle.
  logic [W-1:0] exp_q[$];
  logic [3:0]   wa3_exp_q[$];
  int           m_run_left = 0;
  bit           m_done = 0;
  logic [W-1:0] m_res = '0;
  logic [3:0]   m_wa3 = '0;
  bit           m_z = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run_left = 0;
      m_done     = 0;
      m_res      = '0;
      m_wa3      = '0;
      m_z        = 0;
      exp_q.delete();
      wa3_exp_q.delete();
    end else if (m_run_left > 0) begin
      m_run_left--;
      if (m_run_left == 0) begin
        m_res  = exp_q.pop_front();
        m_wa3  = wa3_exp_q.pop_front();
        m_z    = (m_res == '0);
        m_done = 1;
      end
    end else begin
      m_done = 0;
      if (issue_valid) begin
        exp_q.push_back(model_result(alu_op, vsi_flag, imm_in, src_a, src_b));
        wa3_exp_q.push_back(wa3_in);
        m_run_left = R / LPC;
      end
    end
  end

  // Compare process: control outputs every cycle, data outputs whenever
  // no operation is in flight.
  always @(negedge clk) begin
    check("stall", stall, m_run_left > 0);
    check("res_valid", res_valid, m_done);
    if (m_run_left == 0) begin
      check("result", result, m_res);
      check("res_wa3", res_wa3, m_wa3);
      check("zero_flag", zero_flag, m_z);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] op, input logic [1:0] vsi, input logic [3:0] wa3,
                       input logic [N-1:0] imm, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_op   = op;
    vsi_flag = vsi;
    wa3_in   = wa3;
    imm_in   = imm;
    src_a    = a;
    src_b    = b;
  endtask

  function automatic logic [W-1:0] rand_lanes();
    logic [W-1:0] v;
    logic [N-1:0] pick [5];
    pick[0] = 8'h7F; pick[1] = 8'h80; pick[2] = 8'h00; pick[3] = 8'hFF;
    for (int i = 0; i < R; i++) begin
      pick[4] = N'($urandom);
      v[i*N +: N] = pick[$urandom_range(0, 4)];
    end
    return v;
  endfunction

  task automatic randomize_inputs();
    drive(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 4'($urandom),
          N'($urandom), rand_lanes(), rand_lanes());
  endtask

  // Issue one operation, count edges to the strobe, return the strobed result.
  // With scramble set, issue_valid and operands are randomized during RUN.
  task automatic run_op(input logic [2:0] op, input logic [1:0] vsi, input logic [3:0] wa3,
                        input logic [N-1:0] imm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit scramble, output logic [W-1:0] r, output int lat);
    bit found;
    @(negedge clk);
    drive(op, vsi, wa3, imm, a, b);
    issue_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid) begin
        found = 1;
        break;
      end
      if (scramble) begin
        issue_valid = 1'($urandom_range(0, 1));
        randomize_inputs();
      end else begin
        issue_valid = 1'b0;
      end
      @(posedge clk);
      lat++;
    end
    issue_valid = 1'b0;
    r = result;
    check("strobe_seen", found, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  logic [W-1:0] r;
  logic [W-1:0] tmp;
  int lat;
  int pulses[$];

  initial begin
    repeat (3) @(negedge clk);
    check("reset_stall", stall, 1'b0);
    check("reset_result", result, '0);
    reset = 1'b0;

    // Model pins: hand-computed lane values.
    check("model_add", model_result(3'd0, 2'b00, 8'h00, 48'h101010101010, 48'h060504030201),
          48'h161514131211);
    check("model_sub", model_result(3'd1, 2'b01, 8'h03, 48'h0A0A0A0A0A0A, 48'h0),
          48'h070707070707);
    check("model_mul_shl", {model_result(3'd5, 2'b01, 8'h11, 48'h000000000010, 48'h0)[7:0],
                            model_result(3'd6, 2'b00, 8'h00, 48'h000000000003, 48'h000000000009)[7:0]},
          16'h1006);

    // Vector ADD, first capture right after reset release.
    run_op(3'd0, 2'b00, 4'h5, 8'h00, 48'h101010101010, 48'h060504030201, 0, r, lat);
    check("add_latency", lat, 4);
    check("add_result", r, 48'h161514131211);
    check("add_zero", zero_flag, 1'b0);
    check("add_wa3", res_wa3, 4'h5);

    // XOR of identical operands gives all-zero lanes.
    tmp = rand_lanes();
    run_op(3'd4, 2'b00, 4'h9, 8'h00, tmp, tmp, 0, r, lat);
    check("xor_result", r, '0);
    check("xor_zero", zero_flag, 1'b1);

    // Immediate broadcast ADD at the signed boundary.
    run_op(3'd0, 2'b01, 4'h2, 8'h01, 48'h7F7F7F7F7F7F, rand_lanes(), 0, r, lat);
`ifdef VEC_SAT_EN
    check("add_imm_boundary", r, 48'h7F7F7F7F7F7F);
`else
    check("add_imm_boundary", r, 48'h808080808080);
`endif

    // Operands presented during RUN must be ignored.
    run_op(3'd3, 2'b00, 4'hC, 8'h00, 48'h0F0F0F0F0F0F, 48'hF000F000F000, 1, r, lat);
    check("ignore_run_result", r, 48'hFF0FFF0FFF0F);
    check("ignore_run_latency", lat, 4);

    // Back-to-back: issue held, second capture on the DONE edge.
    @(negedge clk);
    drive(3'd2, 2'b00, 4'h1, 8'h00, 48'hFFFFFFFFFFFF, 48'h0102030405A5);
    issue_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(3'd7, 2'b00, 4'h3, 8'h00, 48'h0, 48'h112233445566);
    for (int c = 0; c < 20 && pulses.size() < 2; c++) begin
      if (res_valid) begin
        pulses.push_back(c);
        if (pulses.size() == 1) check("b2b_first", result, 48'h0102030405A5);
        else                    check("b2b_second", result, 48'h112233445566);
      end
      if (pulses.size() == 1 && c == pulses[0] + 1) begin
        check("b2b_no_idle", stall, 1'b1);
        issue_valid = 1'b0;
      end
      @(negedge clk);
    end
    issue_valid = 1'b0;
    check("b2b_pulses", pulses.size(), 2);
    if (pulses.size() == 2) check("b2b_gap", pulses[1] - pulses[0], 4);

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    drive(3'd0, 2'b00, 4'h7, 8'h00, 48'h010101010101, 48'h010101010101);
    issue_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    issue_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_stall", stall, 1'b0);
    check("abort_result", result, '0);
    check("abort_valid", res_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    run_op(3'd1, 2'b00, 4'hA, 8'h00, 48'h050505050505, 48'h010203040506, 0, r, lat);
    check("post_abort_result", r, 48'h0403020100FF);

    // Randomized issue traffic, including toggling during RUN.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      issue_valid = 1'($urandom_range(0, 2) != 0);
      randomize_inputs();
      if ($urandom_range(0, 150) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
